// File: rtl/ad_lvds_sync_decoder.sv
// ad_lvds_sync_decoder
//   Word aligner and line framer behind the 1:16 LVDS deserializer.
//   Searches every bit offset for the programmed preamble, locks once the
//   same offset has produced ALIGN_CONFIRM complete preambles, then strips
//   each line's preamble/type word and delivers 14-bit pixels.
//
// Ports
//   clk             word clock, one raw word per cycle
//   reset           asynchronous active-high reset
//   iv_word         raw deserialized word (MSB first, arbitrary boundary)
//   iv_sync_word0-2 preamble words
//   iv_sync_word3   line-type word: first line of frame
//   iv_sync_word4   line-type word: ordinary line
//   iv_line_length  active pixels per line, sampled on the type word
//   ov_pix_data     aligned word bits [13:0]
//   o_pix_valid     ov_pix_data valid
//   o_line_start    first pixel of each line
//   o_frame_start   first pixel of a frame-start line
//   o_align_lock    bit alignment locked
//   ov_bit_offset   locked / candidate bit offset
//   o_align_err     one-cycle pulse per bad line-type word while locked
module ad_lvds_sync_decoder #(
  parameter int unsigned ALIGN_CONFIRM = 4,
  parameter int unsigned LOSS_THRESH   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] iv_word,
  input  logic [15:0] iv_sync_word0,
  input  logic [15:0] iv_sync_word1,
  input  logic [15:0] iv_sync_word2,
  input  logic [15:0] iv_sync_word3,
  input  logic [15:0] iv_sync_word4,
  input  logic [12:0] iv_line_length,
  output logic [13:0] ov_pix_data,
  output logic        o_pix_valid,
  output logic        o_line_start,
  output logic        o_frame_start,
  output logic        o_align_lock,
  output logic [3:0]  ov_bit_offset,
  output logic        o_align_err
);

  localparam logic [4:0] CONFIRM_W = 5'(ALIGN_CONFIRM);
  localparam logic [4:0] LOSS_W    = 5'(LOSS_THRESH);

  typedef enum logic [2:0] {
    S_SEARCH,
    S_IDLE,
    S_PRE1,
    S_PRE2,
    S_TYPE,
    S_ACTIVE
  } state_t;

  // Stage 1: raw word pipeline
  logic [15:0] cur_q, prev_q;

  // Stage 2: candidate windows, per-offset preamble matches, aligned word
  logic [31:0] win;
  logic [15:0] cand [16];
  logic [15:0] m0_d, m1_d, m2_d;
  logic [15:0] m0_q, m1_q, m2_q;
  logic [15:0] aligned_d, aligned_q;

  // Stage 3: framer state
  state_t      state_q;
  logic [1:0]  sph_q;       // search progress: 0 want SW0, 1 want SW1, 2 want SW2
  logic [3:0]  srch_k_q;    // offset of the preamble being tracked in search
  logic [3:0]  off_q;       // stored / locked offset
  logic [3:0]  hit_q;
  logic [3:0]  err_q;
  logic [12:0] pix_cnt_q;
  logic        first_q;
  logic        frame_q;

  logic [3:0]  low_k;
  logic        any_m0;
  logic [4:0]  hit_inc;
  logic [4:0]  err_inc;
  logic        is_sw0, is_sw1, is_sw2, is_sw3, is_sw4;

  assign win = {prev_q, cur_q};

  always_comb begin
    for (int unsigned k = 0; k < 16; k++) begin
      cand[k] = win[k +: 16];
      m0_d[k] = (cand[k] == iv_sync_word0);
      m1_d[k] = (cand[k] == iv_sync_word1);
      m2_d[k] = (cand[k] == iv_sync_word2);
    end
    aligned_d = cand[off_q];
  end

  // Lowest matching offset wins when several windows hold SW0.
  always_comb begin
    low_k  = '0;
    any_m0 = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (m0_q[i] && !any_m0) begin
        low_k  = 4'(i);
        any_m0 = 1'b1;
      end
    end
  end

  assign hit_inc = {1'b0, hit_q} + 5'd1;
  assign err_inc = {1'b0, err_q} + 5'd1;
  assign is_sw0  = (aligned_q == iv_sync_word0);
  assign is_sw1  = (aligned_q == iv_sync_word1);
  assign is_sw2  = (aligned_q == iv_sync_word2);
  assign is_sw3  = (aligned_q == iv_sync_word3);
  assign is_sw4  = (aligned_q == iv_sync_word4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q     <= '0;
      prev_q    <= '0;
      m0_q      <= '0;
      m1_q      <= '0;
      m2_q      <= '0;
      aligned_q <= '0;
    end else begin
      cur_q     <= iv_word;
      prev_q    <= cur_q;
      m0_q      <= m0_d;
      m1_q      <= m1_d;
      m2_q      <= m2_d;
      aligned_q <= aligned_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_SEARCH;
      sph_q         <= '0;
      srch_k_q      <= '0;
      off_q         <= '0;
      hit_q         <= '0;
      err_q         <= '0;
      pix_cnt_q     <= '0;
      first_q       <= 1'b0;
      frame_q       <= 1'b0;
      ov_pix_data   <= '0;
      o_pix_valid   <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_align_lock  <= 1'b0;
      o_align_err   <= 1'b0;
    end else begin
      o_pix_valid   <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_align_err   <= 1'b0;

      case (state_q)
        S_SEARCH: begin
          // A broken sequence re-tests the current word as a fresh SW0;
          // the hit counter is left untouched.
          if (sph_q == 2'd1 && m1_q[srch_k_q]) begin
            sph_q <= 2'd2;
          end else if (sph_q == 2'd2 && m2_q[srch_k_q]) begin
            sph_q <= 2'd0;
            if (srch_k_q == off_q) begin
              hit_q <= hit_inc[3:0];
              if (hit_inc >= CONFIRM_W) begin
                o_align_lock <= 1'b1;
                err_q        <= '0;
                state_q      <= S_IDLE;
              end
            end else begin
              off_q <= srch_k_q;
              hit_q <= 4'd1;
              if (CONFIRM_W <= 5'd1) begin
                o_align_lock <= 1'b1;
                err_q        <= '0;
                state_q      <= S_IDLE;
              end
            end
          end else if (any_m0) begin
            srch_k_q <= low_k;
            sph_q    <= 2'd1;
          end else begin
            sph_q <= 2'd0;
          end
        end

        S_IDLE: begin
          if (is_sw0) state_q <= S_PRE1;
        end

        S_PRE1: begin
          if (is_sw1)      state_q <= S_PRE2;
          else if (is_sw0) state_q <= S_PRE1;
          else             state_q <= S_IDLE;
        end

        S_PRE2: begin
          if (is_sw2)      state_q <= S_TYPE;
          else if (is_sw0) state_q <= S_PRE1;
          else             state_q <= S_IDLE;
        end

        S_TYPE: begin
          if (is_sw3 || is_sw4) begin
            frame_q   <= is_sw3;
            first_q   <= 1'b1;
            err_q     <= '0;
            pix_cnt_q <= iv_line_length;
            state_q   <= (iv_line_length == '0) ? S_IDLE : S_ACTIVE;
          end else begin
            o_align_err <= 1'b1;
            if (err_inc >= LOSS_W) begin
              o_align_lock <= 1'b0;
              hit_q        <= '0;
              err_q        <= '0;
              sph_q        <= '0;
              state_q      <= S_SEARCH;
            end else begin
              err_q   <= err_inc[3:0];
              state_q <= S_IDLE;
            end
          end
        end

        S_ACTIVE: begin
          o_pix_valid   <= 1'b1;
          ov_pix_data   <= aligned_q[13:0];
          o_line_start  <= first_q;
          o_frame_start <= first_q & frame_q;
          first_q       <= 1'b0;
          pix_cnt_q     <= pix_cnt_q - 13'd1;
          if (pix_cnt_q == 13'd1) state_q <= S_IDLE;
        end

        default: state_q <= S_SEARCH;
      endcase
    end
  end

  assign ov_bit_offset = off_q;

endmodule
